debug_dump_tx: RTL and testbench

DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

---
 rtl/debug_dump_tx_if.sv | 23 ++
 rtl/debug_dump_tx.sv | 152 +++++++++++++++
 tb/tb_debug_dump_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/debug_dump_tx_if.sv
// Handshake bundle between the debugger receive-side controller, the UART
// transmit FIFO and the snapshot dump engine.
interface debug_dump_tx_if #(
   parameter int NUM_BYTES = 220
);
   logic                   sendSignal;
   logic [8*NUM_BYTES-1:0] sendData;
   logic                   tx_full;
   logic [7:0]             w_data;
   logic                   wr_uart;
   logic                   dataSent;
   logic                   busy;

   modport master (
      output sendSignal, sendData, tx_full,
      input  w_data, wr_uart, dataSent, busy
   );

   modport slave (
      input  sendSignal, sendData, tx_full,
      output w_data, wr_uart, dataSent, busy
   );
endinterface

// File: rtl/debug_dump_tx.sv
// Streams a latched pipeline snapshot byte-by-byte into the UART transmit FIFO.
// Optional trailing XOR checksum byte enabled by macro DEBUG_DUMP_CHECKSUM_EN.
module debug_dump_tx #(
   parameter int NUM_BYTES = 220
) (
   input  logic            clock,
   input  logic            reset,
   debug_dump_tx_if.slave  bus
);
   localparam int CNT_W = $clog2(NUM_BYTES + 2);
`ifdef DEBUG_DUMP_CHECKSUM_EN
   localparam int LAST_IDX = NUM_BYTES;
`else
   localparam int LAST_IDX = NUM_BYTES - 1;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LATCH     = 3'd1,
      WRITE     = 3'd2,
      WAIT_ROOM = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t                       state_r;
   logic [NUM_BYTES-1:0][7:0]    snap_r;
   logic [CNT_W-1:0]             cnt_r;
   logic [7:0]                   cur_byte_r;
   logic                         data_sent_r;
   logic                         busy_r;
   logic [CNT_W-1:0]             next_idx_s;
   logic [7:0]                   next_byte_s;

   function automatic logic [7:0] pick_byte(input logic [NUM_BYTES-1:0][7:0] s,
                                            input logic [CNT_W-1:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (idx == CNT_W'(k)) begin
            b = s[k];
         end
      end
      return b;
   endfunction

`ifdef DEBUG_DUMP_CHECKSUM_EN
   logic [7:0] csum_r;

   function automatic logic [7:0] xor_bytes(input logic [NUM_BYTES-1:0][7:0] s);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < NUM_BYTES; k++) begin
         acc = acc ^ s[k];
      end
      return acc;
   endfunction

   // Checksum is taken from the same data that is latched into the snapshot.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         csum_r <= 8'h00;
      end else if (state_r == LATCH) begin
         csum_r <= xor_bytes(bus.sendData);
      end else begin
         csum_r <= csum_r;
      end
   end
`endif

   // Pre-select the byte that follows the one currently on w_data.
   always_comb begin
      next_idx_s = cnt_r + CNT_W'(1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
      if (next_idx_s == CNT_W'(NUM_BYTES)) begin
         next_byte_s = csum_r;
      end else begin
         next_byte_s = pick_byte(snap_r, next_idx_s);
      end
`else
      next_byte_s = pick_byte(snap_r, next_idx_s);
`endif
   end

   // Dump sequencer; w_data always holds the byte at the current counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         snap_r      <= '0;
         cnt_r       <= '0;
         cur_byte_r  <= 8'h00;
         data_sent_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.sendSignal) begin
                  state_r <= LATCH;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            LATCH: begin
               snap_r     <= bus.sendData;
               cur_byte_r <= bus.sendData[7:0];
               cnt_r      <= '0;
               state_r    <= WRITE;
            end
            WRITE: begin
               if (!bus.tx_full) begin
                  cur_byte_r <= next_byte_s;
                  if (cnt_r == CNT_W'(LAST_IDX)) begin
                     state_r     <= DONE;
                     data_sent_r <= 1'b1;
                  end else begin
                     cnt_r <= next_idx_s;
                  end
               end else begin
                  state_r <= WAIT_ROOM;
               end
            end
            WAIT_ROOM: begin
               if (!bus.tx_full) begin
                  state_r <= WRITE;
               end else begin
                  state_r <= WAIT_ROOM;
               end
            end
            DONE: begin
               if (!bus.sendSignal) begin
                  state_r     <= IDLE;
                  data_sent_r <= 1'b0;
                  busy_r      <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               data_sent_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Strobe is gated by tx_full in the same cycle so a full FIFO is never written.
   assign bus.wr_uart  = (state_r == WRITE) && !bus.tx_full;
   assign bus.w_data   = cur_byte_r;
   assign bus.dataSent = data_sent_r;
   assign bus.busy     = busy_r;
endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected byte streams are queued at
// request time and a negedge monitor pops them on every write strobe.
module tb_debug_dump_tx;
   localparam int NB = 4;
`ifdef DEBUG_DUMP_CHECKSUM_EN
   localparam int TOTAL = NB + 1;
`else
   localparam int TOTAL = NB;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   strobe_cnt = 0;
   int   cyc = 0;
   int   first_cyc = 0;
   int   last_cyc = 0;
   logic [7:0] exp_q[$];

   debug_dump_tx_if #(.NUM_BYTES(NB)) bus();
   debug_dump_tx #(.NUM_BYTES(NB)) dut (.clock(clk), .reset(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: bytes LSB first, optional XOR of all bytes appended.
   task automatic push_expected(input logic [8*NB-1:0] d);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < NB; k++) begin
         exp_q.push_back(d[8*k +: 8]);
         x = x ^ d[8*k +: 8];
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.wr_uart) begin
         strobe_cnt++;
         if (strobe_cnt == 1) first_cyc = cyc;
         last_cyc = cyc;
         chk("wr_while_full", {63'd0, bus.tx_full}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 64'd1, 64'd0);
         end else begin
            chk("w_data", {56'd0, bus.w_data}, {56'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic start_dump(input logic [8*NB-1:0] d);
      @(posedge clk); #1;
      push_expected(d);
      strobe_cnt = 0;
      bus.sendData = d;
      bus.sendSignal = 1'b1;
   endtask

   task automatic wait_strobes(input int n, input string name);
      int t;
      t = 0;
      while (strobe_cnt < n && t < 200) begin
         @(negedge clk); #1;
         t++;
      end
      chk(name, {63'd0, (strobe_cnt >= n)}, 64'd1);
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (!bus.dataSent && t < 200) begin
         @(negedge clk); #1;
         t++;
      end
      chk(name, {63'd0, bus.dataSent}, 64'd1);
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_strobes"}, 64'(strobe_cnt), 64'(TOTAL));
   endtask

   task automatic finish_dump(input string name);
      @(posedge clk); #1;
      bus.sendSignal = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_datasent_clr"}, {63'd0, bus.dataSent}, 64'd0);
      chk({name, "_busy_clr"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      logic [8*NB-1:0] d;
      int n;
      int drop_at;
      bit held;
      bit seen_sent;

      bus.sendSignal = 1'b0;
      bus.sendData = '0;
      bus.tx_full = 1'b0;
      #2;
      chk("rst_w_data", {56'd0, bus.w_data}, 64'd0);
      chk("rst_wr_uart", {63'd0, bus.wr_uart}, 64'd0);
      chk("rst_dataSent", {63'd0, bus.dataSent}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      #20 rst_n = 1'b1;

      // Basic dump at full rate, then sendSignal held after completion.
      start_dump(32'h44332211);
      wait_done("basic");
      chk("basic_back_to_back", 64'(last_cyc - first_cyc), 64'(TOTAL - 1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_dataSent", {63'd0, bus.dataSent}, 64'd1);
         chk("hold_busy", {63'd0, bus.busy}, 64'd1);
      end
      chk("hold_no_strobe", 64'(strobe_cnt), 64'(TOTAL));
      finish_dump("basic");

      // FIFO full for 10 cycles after the second byte.
      start_dump(32'h44332211);
      wait_strobes(2, "stall_reach2");
      @(posedge clk); #1;
      bus.tx_full = 1'b1;
      repeat (10) @(negedge clk);
      chk("stall_no_strobe", 64'(strobe_cnt), 64'd2);
      @(posedge clk); #1;
      bus.tx_full = 1'b0;
      @(negedge clk);
      chk("stall_exit_cycle", {63'd0, bus.wr_uart}, 64'd0);
      @(negedge clk);
      chk("stall_third_strobe", {63'd0, bus.wr_uart}, 64'd1);
      chk("stall_third_byte", {56'd0, bus.w_data}, 64'h33);
      wait_done("stall");
      finish_dump("stall");

      // Source data changes right after it is latched.
      start_dump(32'h44332211);
      @(posedge clk);
      @(posedge clk); #1;
      bus.sendData = 32'hFFFFFFFF;
      wait_done("latch_iso");
      finish_dump("latch_iso");

      // Reset in the middle of a dump.
      start_dump(32'h44332211);
      wait_strobes(2, "rst_reach2");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_w_data", {56'd0, bus.w_data}, 64'd0);
      chk("midrst_wr_uart", {63'd0, bus.wr_uart}, 64'd0);
      chk("midrst_dataSent", {63'd0, bus.dataSent}, 64'd0);
      chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
      exp_q.delete();
      bus.sendSignal = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", {63'd0, bus.busy}, 64'd0);
      start_dump(32'h44332211);
      wait_done("restart");
      finish_dump("restart");

      // Random data, random FIFO back-pressure, random early request drop.
      for (int t = 0; t < 12; t++) begin
         d = $urandom;
         start_dump(d);
         drop_at = $urandom_range(1, 12);
         held = ($urandom_range(0, 1) == 1);
         seen_sent = 1'b0;
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
            bus.tx_full = ($urandom_range(0, 2) == 0);
            if (bus.dataSent) seen_sent = 1'b1;
            if (!held && n == drop_at) bus.sendSignal = 1'b0;
            if (held && bus.dataSent) bus.sendSignal = 1'b0;
         end while (bus.busy && n < 300);
         bus.tx_full = 1'b0;
         bus.sendSignal = 1'b0;
         chk("rand_finished", {63'd0, bus.busy}, 64'd0);
         chk("rand_seen_sent", {63'd0, seen_sent}, 64'd1);
         chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
         chk("rand_strobes", 64'(strobe_cnt), 64'(TOTAL));
         exp_q.delete();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
